pwm_ramp_seq: RTL and testbench

PWM_RAMP_SEQ -- requirements
Module: pwm_ramp_seq

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_tick_gen.sv | 31 +++
 rtl/pwm_ramp_seq.sv | 187 ++++++++++++++++++
 tb/tb_pwm_ramp_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared register map and sequencer state encoding for the PWM ramp sequencer.
package pwm_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [ADDR_W-1:0] CTRL_1       = 6'd0;
    localparam logic [ADDR_W-1:0] CTRL_2       = 6'd1;
    localparam logic [ADDR_W-1:0] CH_CTRL_BASE = 6'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EN_WR     = 3'd1,
        WAIT_TICK = 3'd2,
        SCAN      = 3'd3,
        DUTY_WR   = 3'd4,
        FIN       = 3'd5
    } pwm_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Tick prescaler: counts 0..div and fires on reaching div; clr holds it at 0.
module pwm_tick_gen #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] div,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_seq.sv
// Ramps per-channel PWM duty values toward latched targets, one step per tick,
// pushing each new duty and the channel enable mask out over an Avalon-MM master.
module pwm_ramp_seq
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [NUM_CH-1:0]           en_mask,
    input  logic [NUM_CH*CNT_WIDTH-1:0] target,
    input  logic [CNT_WIDTH-1:0]        step,
    input  logic [CNT_WIDTH-1:0]        tick_div,
    output logic                        m_chipselect,
    output logic                        m_write,
    output logic [ADDR_W-1:0]           m_address,
    output logic [BE_W-1:0]             m_byteenable,
    output logic [DATA_W-1:0]           m_writedata,
    input  logic                        m_waitrequest,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned VEC_W = NUM_CH * CNT_WIDTH;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

    pwm_state_e           state_q, state_d;
    logic [IDX_W-1:0]     ch_q, ch_d;
    logic [VEC_W-1:0]     cur_q, cur_d, tgt_q, tgt_d;
    logic [CNT_WIDTH-1:0] step_q, step_d, div_q, div_d;
    logic                 req_q, req_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 busy_q, done_q;
    logic                 tick;
    logic                 scan_next;

    logic [CNT_WIDTH-1:0] cur_ch, tgt_ch, new_val;
    logic [CNT_WIDTH:0]   cur_x, tgt_x, step_x, sum_x, diff_x;

    pwm_tick_gen #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .clr    (state_q != WAIT_TICK),
        .div    (div_q),
        .tick   (tick)
    );

    // Next duty for the selected channel, one bit wider so step never wraps.
    always_comb begin
        cur_ch  = cur_q[ch_q*CNT_WIDTH +: CNT_WIDTH];
        tgt_ch  = tgt_q[ch_q*CNT_WIDTH +: CNT_WIDTH];
        cur_x   = {1'b0, cur_ch};
        tgt_x   = {1'b0, tgt_ch};
        step_x  = {1'b0, step_q};
        sum_x   = cur_x + step_x;
        diff_x  = cur_x - step_x;
        new_val = tgt_ch;
        if (cur_ch < tgt_ch) begin
            if (sum_x <= tgt_x) begin
                new_val = sum_x[CNT_WIDTH-1:0];
            end
        end else if (!diff_x[CNT_WIDTH] && (diff_x >= tgt_x)) begin
            new_val = diff_x[CNT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        step_d    = step_q;
        div_d     = div_q;
        req_d     = req_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        scan_next = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    step_d  = (step == '0) ? CNT_WIDTH'(1) : step;
                    div_d   = tick_div;
                    req_d   = 1'b1;
                    addr_d  = CTRL_2;
                    be_d    = 4'hF;
                    wdata_d = DATA_W'(en_mask);
                    state_d = EN_WR;
                end
            end
            EN_WR: begin
                if (!m_waitrequest) begin
                    req_d   = 1'b0;
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    ch_d    = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cur_ch != tgt_ch) begin
                    req_d   = 1'b1;
                    addr_d  = CH_CTRL_BASE + ADDR_W'(ch_q);
                    be_d    = 4'hF;
                    wdata_d = DATA_W'(new_val);
                    state_d = DUTY_WR;
                end else begin
                    scan_next = 1'b1;
                end
            end
            DUTY_WR: begin
                if (!m_waitrequest) begin
                    req_d = 1'b0;
                    cur_d[ch_q*CNT_WIDTH +: CNT_WIDTH] = wdata_q[CNT_WIDTH-1:0];
                    scan_next = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // cur_d already carries a just-completed duty write into the finish test.
        if (scan_next) begin
            if (ch_q == LAST_CH) begin
                state_d = (cur_d == tgt_q) ? FIN : WAIT_TICK;
            end else begin
                ch_d    = ch_q + IDX_W'(1);
                state_d = SCAN;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cur_q   <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            div_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= CTRL_1;
            be_q    <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            div_q   <= div_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == FIN);
        end
    end

    assign m_chipselect = req_q;
    assign m_write      = req_q;
    assign m_address    = addr_q;
    assign m_byteenable = be_q;
    assign m_writedata  = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pwm_ramp_seq.sv
// Scoreboard bench for pwm_ramp_seq: stimulus queues expected bus writes and done
// pulses, a negedge monitor pops and compares them as the DUT produces them.
module tb_pwm_ramp_seq;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CW     = 16;

    typedef struct {
        bit          is_done;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic                   clock;
    logic                   resetn;
    logic                   start;
    logic [NUM_CH-1:0]      en_mask;
    logic [NUM_CH*CW-1:0]   target;
    logic [CW-1:0]          step;
    logic [CW-1:0]          tick_div;
    logic                   m_chipselect;
    logic                   m_write;
    logic [5:0]             m_address;
    logic [3:0]             m_byteenable;
    logic [31:0]            m_writedata;
    logic                   m_waitrequest;
    logic                   busy;
    logic                   done;

    exp_t exp_q[$];
    int   duty_t[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   done_prev = 1'b0;

    pwm_ramp_seq #(
        .NUM_CH    (NUM_CH),
        .CNT_WIDTH (CW)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .en_mask       (en_mask),
        .target        (target),
        .step          (step),
        .tick_div      (tick_div),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = a;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.addr    = '0;
        e.data    = '0;
        exp_q.push_back(e);
    endtask

    task automatic kick(input logic [NUM_CH-1:0] m, input logic [CW-1:0] t0,
                        input logic [CW-1:0] t1, input logic [CW-1:0] st,
                        input logic [CW-1:0] dv);
        en_mask  = m;
        target   = {t1, t0};
        step     = st;
        tick_div = dv;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
    endtask

    task automatic wait_cs(input string name, input int limit);
        int k = 0;
        while (!m_chipselect && k < limit) begin
            @(posedge clock); #1;
            k++;
        end
        if (!m_chipselect) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no write request within %0d cycles", name, limit);
        end
    endtask

    task automatic drain(input string name, input int limit);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < limit) begin
            @(posedge clock); #1;
            k++;
        end
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_idle"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every accepted write and every done pulse must match the queue head.
    always @(negedge clock) begin
        cyc++;
        if (resetn) begin
            if (m_chipselect && m_write && !m_waitrequest) begin
                if (m_address >= 6'd2) duty_t.push_back(cyc);
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wr_order: got write addr %0d data 0x%0h, required %s",
                             m_address, m_writedata, (exp_q.size() == 0) ? "none" : "done");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(m_address), 32'(mon_e.addr));
                    chk("wr_data", m_writedata, mon_e.data);
                    chk("wr_be", 32'(m_byteenable), 32'hF);
                end
            end
            if (done) begin
                n_vec++;
                if (done_prev) begin
                    n_err++;
                    $display("FAIL done_width: got done high 2 cycles, required 1");
                end else if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    n_err++;
                    $display("FAIL done_order: got done, required %s",
                             (exp_q.size() == 0) ? "none" : "write");
                end else begin
                    mon_e = exp_q.pop_front();
                end
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn        = 1'b0;
        start         = 1'b0;
        en_mask       = '0;
        target        = '0;
        step          = '0;
        tick_div      = '0;
        m_waitrequest = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cs", 32'(m_chipselect), 32'd0);
        chk("rst_write", 32'(m_write), 32'd0);
        chk("rst_addr", 32'(m_address), 32'd0);
        chk("rst_data", m_writedata, 32'd0);
        chk("rst_be", 32'(m_byteenable), 32'd0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Basic ramp: ch0 -> 0x10, ch1 -> 0x04, step 4, tick every cycle.
        push_wr(6'd1, 32'h3);
        push_wr(6'd2, 32'h4);
        push_wr(6'd3, 32'h4);
        push_wr(6'd2, 32'h8);
        push_wr(6'd2, 32'hC);
        push_wr(6'd2, 32'h10);
        push_done();
        kick(2'b11, 16'h0010, 16'h0004, 16'd4, 16'd0);
        chk("busy_run", 32'(busy), 32'd1);
        drain("ramp_basic", 300);

        // Downward ramp with clamp: ch0 0x10 -> 0x03 by 8.
        push_wr(6'd1, 32'h1);
        push_wr(6'd2, 32'h8);
        push_wr(6'd2, 32'h3);
        push_done();
        kick(2'b01, 16'h0003, 16'h0004, 16'd8, 16'd0);
        drain("ramp_down", 300);

        // Waitrequest stall on first duty write; step 0 behaves as 1.
        push_wr(6'd1, 32'h1);
        push_wr(6'd2, 32'h4);
        push_wr(6'd2, 32'h5);
        push_done();
        m_waitrequest = 1'b1;
        kick(2'b01, 16'h0005, 16'h0004, 16'd0, 16'd0);
        m_waitrequest = 1'b0;
        @(posedge clock); #1;
        m_waitrequest = 1'b1;
        wait_cs("stall_req", 50);
        for (int k = 0; k < 4; k++) begin
            chk("stall_cs", 32'(m_chipselect), 32'd1);
            chk("stall_addr", 32'(m_address), 32'd2);
            chk("stall_data", m_writedata, 32'h4);
            if (k < 3) begin
                @(posedge clock); #1;
            end
        end
        m_waitrequest = 1'b0;
        drain("stall", 300);

        // Slow tick (div 4) plus a start pulse while busy that must be ignored.
        duty_t.delete();
        push_wr(6'd1, 32'h3);
        push_wr(6'd2, 32'h9);
        push_wr(6'd2, 32'hD);
        push_wr(6'd2, 32'h11);
        push_done();
        kick(2'b11, 16'h0011, 16'h0004, 16'd4, 16'd4);
        repeat (3) @(posedge clock);
        #1;
        kick(2'b10, 16'h0040, 16'h0040, 16'd1, 16'd0);
        drain("slow_tick", 600);
        chk("tick_writes", 32'(duty_t.size()), 32'd3);
        for (int k = 1; k < duty_t.size(); k++) begin
            n_vec++;
            if (duty_t[k] - duty_t[k-1] < 5) begin
                n_err++;
                $display("FAIL tick_gap: got %0d cycles, required >= 5", duty_t[k] - duty_t[k-1]);
            end
        end

        // Targets already reached: only the enable write, then done.
        push_wr(6'd1, 32'h3);
        push_done();
        kick(2'b11, 16'h0011, 16'h0004, 16'd1, 16'd2);
        drain("no_change", 300);

        // Reset during a stalled duty write, then ramp again from zero.
        push_wr(6'd1, 32'h3);
        m_waitrequest = 1'b0;
        kick(2'b11, 16'h0021, 16'h0004, 16'h0010, 16'd0);
        @(posedge clock); #1;
        m_waitrequest = 1'b1;
        wait_cs("abort_req", 50);
        chk("abort_pre_addr", 32'(m_address), 32'd2);
        chk("abort_pre_data", m_writedata, 32'h21);
        resetn = 1'b0;
        #1;
        chk("abort_write", 32'(m_write), 32'd0);
        chk("abort_cs", 32'(m_chipselect), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(m_address), 32'd0);
        chk("abort_pending", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        m_waitrequest = 1'b0;
        resetn = 1'b1;
        @(posedge clock); #1;
        push_wr(6'd1, 32'h1);
        push_wr(6'd2, 32'h4);
        push_wr(6'd2, 32'h8);
        push_done();
        kick(2'b01, 16'h0008, 16'h0000, 16'd4, 16'd0);
        drain("after_reset", 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
